// File: rtl/mux_scan_ctrl.sv
// Four-digit multiplexed display scanner: holds four hex nibbles and time-shares
// one 7-segment decoder by cycling GAP (all off) and SHOW (one digit on) intervals.
module mux_scan_ctrl #(
    parameter int DIV   = 1000,
    parameter int BLANK = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        LZS,
    input  logic        WE,
    input  logic [1:0]  WADDR,
    input  logic [3:0]  WDATA,
    input  logic        LOAD,
    input  logic [15:0] LDATA,
    output logic [3:0]  NIB,
    output logic [3:0]  DIG,
    output logic        BL,
    output logic        FRAME
);

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
    localparam logic [7:0]  GAP_LAST = 8'(BLANK - 1);

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [15:0] r_pre;
    logic [7:0]  r_gap;
    logic [15:0] r_digits;
    logic [3:0]  r_dig;
    logic        r_bl;
    logic        r_frame;

    state_t      w_state;
    logic [1:0]  w_idx;
    logic [15:0] w_pre;
    logic [7:0]  w_gap;
    logic [15:0] w_digits;
    logic        w_lit;
    logic        w_frame;

    // A digit is blanked when it and every more significant digit are zero; digit 0 always shows.
    function automatic logic f_suppressed(input logic [15:0] digits, input logic [1:0] idx,
                                          input logic lzs);
        logic zero_s;
        case (idx)
            2'd1:    zero_s = (digits[15:4]  == 12'h000);
            2'd2:    zero_s = (digits[15:8]  == 8'h00);
            2'd3:    zero_s = (digits[15:12] == 4'h0);
            default: zero_s = 1'b0;
        endcase
        return lzs & zero_s;
    endfunction

    assign NIB = r_digits[{r_idx, 2'b00} +: 4];

    // Digit register write path; a bulk load overrides a same-cycle single write.
    always_comb begin
        w_digits = r_digits;
        if (LOAD) begin
            w_digits = LDATA;
        end else if (WE) begin
            w_digits[{WADDR, 2'b00} +: 4] = WDATA;
        end else begin
            w_digits = r_digits;
        end
    end

    // Scan sequencing: counters only advance while enabled, so a freeze resumes mid-interval.
    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_pre   = r_pre;
        w_gap   = r_gap;
        if (EN) begin
            case (r_state)
                GAP: begin
                    if (r_gap == GAP_LAST) begin
                        w_state = SHOW;
                        w_pre   = 16'd0;
                    end else begin
                        w_gap = r_gap + 8'd1;
                    end
                end
                SHOW: begin
                    if (r_pre == DIV_LAST) begin
                        w_state = GAP;
                        w_gap   = 8'd0;
                        w_idx   = r_idx + 2'd1;
                    end else begin
                        w_pre = r_pre + 16'd1;
                    end
                end
                default: begin
                    w_state = GAP;
                    w_gap   = 8'd0;
                end
            endcase
        end else begin
            w_state = r_state;
        end
    end

    // Outputs are derived from the next state so they switch on the same edge as the state.
    always_comb begin
        w_lit   = EN && (w_state == SHOW) && !f_suppressed(w_digits, w_idx, LZS);
        w_frame = EN && (w_state == SHOW) && (w_pre == 16'd0) && (w_idx == 2'd0);
    end

    // State, counters, digit storage and registered Moore outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= GAP;
            r_idx    <= 2'd0;
            r_pre    <= 16'd0;
            r_gap    <= 8'd0;
            r_digits <= 16'h0000;
            r_dig    <= 4'b0000;
            r_bl     <= 1'b1;
            r_frame  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_idx    <= w_idx;
            r_pre    <= w_pre;
            r_gap    <= w_gap;
            r_digits <= w_digits;
            r_dig    <= w_lit ? (4'b0001 << w_idx) : 4'b0000;
            r_bl     <= ~w_lit;
            r_frame  <= w_frame;
        end
    end

    assign DIG   = r_dig;
    assign BL    = r_bl;
    assign FRAME = r_frame;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: directed scenarios plus random stimulus,
// compared every cycle against a position-in-period reference model.
module tb_mux_scan_ctrl;

    localparam int DIV   = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = DIV + BLANK;
    localparam int PER   = 4 * SLOT;

    logic        CLK = 1'b0;
    logic        RST, EN, LZS, WE, LOAD;
    logic [1:0]  WADDR;
    logic [3:0]  WDATA;
    logic [15:0] LDATA;
    logic [3:0]  NIB, DIG;
    logic        BL, FRAME;

    mux_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .LZS(LZS), .WE(WE), .WADDR(WADDR),
        .WDATA(WDATA), .LOAD(LOAD), .LDATA(LDATA), .NIB(NIB), .DIG(DIG),
        .BL(BL), .FRAME(FRAME)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          pos = 0;
    logic [15:0] m_digits = 16'h0000;
    logic [3:0]  e_dig;
    logic        e_bl, e_frame;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Model: pos counts enabled cycles since reset; each digit owns BLANK dark then DIV lit cycles.
    task automatic model_step();
        int d, w;
        if (RST) begin
            pos = 0;
            m_digits = 16'h0000;
            e_dig = 4'b0000; e_bl = 1'b1; e_frame = 1'b0;
        end else begin
            if (LOAD) m_digits = LDATA;
            else if (WE) m_digits[WADDR*4 +: 4] = WDATA;
            if (EN) begin
                pos = (pos + 1) % PER;
                d = pos / SLOT;
                w = pos % SLOT;
                if (w >= BLANK && !(LZS && d > 0 && (m_digits >> (4 * d)) == 16'h0000))
                    e_dig = 4'(1 << d);
                else
                    e_dig = 4'b0000;
                e_bl = (e_dig == 4'b0000);
                e_frame = (w == BLANK) && (d == 0);
            end else begin
                e_dig = 4'b0000; e_bl = 1'b1; e_frame = 1'b0;
            end
        end
    endtask

    task automatic tick();
        logic [15:0] nib_exp;
        @(posedge CLK);
        model_step();
        cyc++;
        #1;
        nib_exp = (m_digits >> (4 * (pos / SLOT))) & 16'h000F;
        chk("DIG", 16'(DIG), 16'(e_dig));
        chk("BL", 16'(BL), 16'(e_bl));
        chk("FRAME", 16'(FRAME), 16'(e_frame));
        chk("NIB", 16'(NIB), nib_exp);
    endtask

    task automatic wait_pos(input int target);
        int n;
        n = 0;
        while (pos != target && n < 2 * PER) begin
            tick();
            n++;
        end
        chk("wait_pos", 16'(pos), 16'(target));
    endtask

    initial begin
        int last_frame, rem, gaps;
        RST = 1'b1; EN = 1'b1; LZS = 1'b0; WE = 1'b0; LOAD = 1'b0;
        WADDR = 2'd0; WDATA = 4'h0; LDATA = 16'h0000;
        tick();
        tick();
        RST = 1'b0;

        // Basic scan of 1234 with period measurement between FRAME pulses.
        LOAD = 1'b1; LDATA = 16'h1234;
        tick();
        LOAD = 1'b0;
        last_frame = -1;
        for (int i = 0; i < 3 * PER; i++) begin
            tick();
            if (FRAME === 1'b1) begin
                if (last_frame >= 0) chk("period", 16'(cyc - last_frame), 16'(PER));
                last_frame = cyc;
            end
        end

        // Leading-zero suppression on 0050.
        LZS = 1'b1; LOAD = 1'b1; LDATA = 16'h0050;
        tick();
        LOAD = 1'b0;
        repeat (PER + 2) tick();
        LZS = 1'b0;

        // LOAD wins over WE in the same cycle.
        LOAD = 1'b1; LDATA = 16'hABCD; WE = 1'b1; WADDR = 2'd0; WDATA = 4'h7;
        tick();
        LOAD = 1'b0; WE = 1'b0;
        wait_pos(BLANK);
        chk("conflict_nib", 16'(NIB), 16'h000D);

        // Live write to the shown digit during its first lit cycle.
        wait_pos(SLOT + BLANK);
        WE = 1'b1; WADDR = 2'd1; WDATA = 4'h9;
        tick();
        WE = 1'b0;
        chk("live_nib", 16'(NIB), 16'h0009);
        repeat (PER) tick();

        // Freeze in the second lit cycle of digit 1, then count remaining lit cycles.
        wait_pos(SLOT + BLANK + 1);
        EN = 1'b0;
        repeat (10) tick();
        EN = 1'b1;
        rem = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (DIG === 4'b0010) rem++;
            else break;
        end
        chk("freeze_rem", 16'(rem), 16'(2));

        // Reset in the middle of digit 2's lit interval.
        wait_pos(2 * SLOT + BLANK + 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_nib", 16'(NIB), 16'h0000);
        gaps = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (DIG === 4'b0000) gaps++;
            else break;
        end
        chk("rst_gaps", 16'(gaps), 16'(BLANK));
        chk("rst_dig", 16'(DIG), 16'h0001);
        chk("rst_frame", 16'(FRAME), 16'h0001);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            EN    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) LZS = ~LZS;
            LOAD  = ($urandom_range(0, 29) == 0);
            for (int k = 0; k < 4; k++)
                LDATA[k*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            WE    = ($urandom_range(0, 9) == 0);
            WADDR = 2'($urandom);
            WDATA = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            RST   = ($urandom_range(0, 199) == 0);
            tick();
        end
        RST = 1'b0; WE = 1'b0; LOAD = 1'b0; EN = 1'b1;
        repeat (PER) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter DIV, default 1000: clock cycles each digit is shown; legal range 1..65535.
REQ-002 Parameter BLANK, default 2: all-off clock cycles between digits, used for anti-ghosting; legal range 1..255.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous reset, active-high.
REQ-005 EN  input  1  scan enable; low = display dark, scan frozen.
REQ-006 LZS  input  1  leading-zero suppression enable.
REQ-007 WE  input  1  single-digit write strobe.
REQ-008 WADDR  input  2  digit index for WE; 0 = least significant.
REQ-009 WDATA  input  4  nibble value for WE.
REQ-010 LOAD  input  1  bulk write strobe for all four digits.
REQ-011 LDATA  input  16  bulk value; [3:0] = digit 0 ... [15:12] = digit 3.
REQ-012 NIB  output  4  nibble for the shared hex-to-7-segment decoder; bit 0 maps to decoder input A, bit 3 to D.
REQ-013 DIG  output  4  one-hot digit enables, active-high; bit k drives digit k.
REQ-014 BL  output  1  blank flag, high whenever DIG is 0.
REQ-015 FRAME  output  1  one-cycle pulse at the start of each digit-0 show interval.

Function
REQ-016 The block SHALL hold four 4-bit digit registers; writes are always accepted (no ready), taking effect at the clock edge where the strobe is sampled.
REQ-017 The block SHALL let LOAD take precedence when LOAD and WE are both high in one cycle, ignoring WE that cycle.
REQ-018 The block SHALL accept writes regardless of EN or FSM state.
REQ-019 The FSM SHALL have exactly two states: GAP (all digits off) and SHOW (digit idx on).
REQ-020 The block SHALL keep GAP for exactly BLANK cycles and then enter SHOW with the prescaler at 0.
REQ-021 The block SHALL keep SHOW for exactly DIV cycles, then enter GAP with idx incremented modulo 4 (3 wraps to 0).
REQ-022 The full scan period SHALL be 4*(DIV+BLANK) cycles while EN is high.
REQ-023 DIG, BL and FRAME SHALL be registered Moore outputs that change on the same edge as the state register.
REQ-024 In SHOW, DIG SHALL equal the one-hot encoding of idx and BL SHALL be 0, unless the digit is suppressed (REQ-027).
REQ-025 In GAP, DIG SHALL be 0 and BL SHALL be 1.
REQ-026 NIB SHALL equal digit[idx] combinationally from the registers, so a write to the shown digit appears on NIB in the cycle after the write edge.
REQ-027 With LZS=1, digit k (k=1..3) SHALL be suppressed (DIG=0, BL=1, state timing unchanged) when digit k and all higher digits are 0; digit 0 is never suppressed.
REQ-028 FRAME SHALL be 1 only in the first SHOW cycle of idx 0 and 0 otherwise.
REQ-029 With EN=0, the block SHALL force DIG=0, BL=1 and FRAME=0, and freeze state, idx and both counters.
REQ-030 When EN returns high, the block SHALL resume the frozen interval with its remaining count.
REQ-031 The prescaler SHALL be 16 bits and the gap counter 8 bits, with no overflow for legal parameter values.

Reset
REQ-032 RST SHALL take precedence over all other inputs, including EN, LOAD and WE.
REQ-033 On RST, the block SHALL clear all four digit registers, set idx=0 and both counters to 0, and enter GAP.
REQ-034 During reset and the cycle after it, outputs SHALL be DIG=0, BL=1, FRAME=0 and NIB=0.
REQ-035 Asserting RST during SHOW or GAP SHALL abort the interval, with outputs per REQ-034 on the next edge.
REQ-036 After RST is released, the block SHALL hold GAP for BLANK cycles and then show digit 0 with FRAME=1, without advancing idx first.

Verification
REQ-037 Scan sequence, DIV=4, BLANK=2, LDATA=16'h1234 loaded, EN=1:
- 2 cycles DIG=0.
- 4 cycles DIG=0001 NIB=4, FRAME high on the first only.
- 2 cycles DIG=0.
- 4 cycles DIG=0010 NIB=3, then digits 2 and 3 likewise.
- Period 24 cycles.
REQ-038 LZS, LDATA=16'h0050, LZS=1: digits 3 and 2 show BL=1 DIG=0; digit 1 shows NIB=5 DIG=0010; digit 0 shows NIB=0 DIG=0001.
REQ-039 Conflict write: LOAD=1 LDATA=16'hABCD with WE=1 WADDR=0 WDATA=7 in the same cycle -> digit 0 holds D.
REQ-040 Live update: WE to the shown digit in SHOW cycle 1 -> NIB changes in the next cycle, with no timing disturbance.
REQ-041 Freeze: EN=0 for 10 cycles in SHOW cycle 2 of digit 1 -> DIG=0 and BL=1 throughout; after EN=1, digit 1 is shown for 2 more cycles.
REQ-042 Mid-reset: RST asserted in SHOW of digit 2 -> next edge DIG=0 and NIB=0; after release, 2 GAP cycles, then DIG=0001 with FRAME=1.
